// File: rtl/dmem_responder.sv
// dmem_responder: valid/ready data-memory slave with byte-enable SRAM, programmable wait states and misalignment errors
module dmem_responder #(
  parameter int W           = 32,
  parameter int D           = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic         i_req_valid,
  output logic         o_req_ready,
  input  logic [D-1:0] i_req_addr,
  input  logic         i_req_we,
  input  logic [W-1:0] i_req_wdata,
  input  logic [3:0]   i_req_be,
  output logic         o_rsp_valid,
  input  logic         i_rsp_ready,
  output logic [W-1:0] o_rsp_rdata,
  output logic         o_rsp_err
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  state_t       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [D-1:0] addr_q, addr_d;
  logic         we_q, we_d;
  logic [W-1:0] wdata_q, wdata_d;
  logic [3:0]   be_q, be_d;
  logic [W-1:0] rdata_q, rdata_d;
  logic         err_q, err_d;
  logic [W-1:0] mem [0:2**(D-2)-1];
  logic [W-1:0] rd_word, be_mask;
  logic         access, mis, mem_we;
  always_comb begin
    rd_word = mem[addr_q[D-1:2]];
    be_mask = {{8{be_q[3]}}, {8{be_q[2]}}, {8{be_q[1]}}, {8{be_q[0]}}};
    mis     = |addr_q[1:0];
    access  = (state_q == S_WAIT) && (cnt_q == 4'd0);
    mem_we  = access && we_q && !mis && |be_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: if (i_req_valid) begin
        state_d = S_WAIT;
        cnt_d   = 4'(WAIT_STATES);
        addr_d  = i_req_addr;
        we_d    = i_req_we;
        wdata_d = i_req_wdata;
        be_d    = i_req_be;
      end
      S_WAIT: if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
      else begin
        state_d = S_RESP;
        err_d   = mis;
        rdata_d = (mis || we_q) ? '0 : rd_word;
      end
      S_RESP: if (i_rsp_ready) begin
        state_d = S_IDLE;
        rdata_d = '0;
        err_d   = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  always_ff @(posedge i_clk)
    if (mem_we) mem[addr_q[D-1:2]] <= (rd_word & ~be_mask) | (wdata_q & be_mask);
  assign o_req_ready = (state_q == S_IDLE);
  assign o_rsp_valid = (state_q == S_RESP);
  assign o_rsp_rdata = rdata_q;
  assign o_rsp_err   = err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for dmem_responder with one and zero wait states
module tb_dmem_responder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic        err [2];
  logic [31:0] rdata [2];
  typedef struct packed {logic [31:0] rdata; logic err;} exp_t;
  exp_t q0[$], q1[$];
  exp_t e0, e1;
  int n_tests = 0, n_fail = 0;
  always #5 clk = ~clk;
  dmem_responder #(.W(32), .D(8), .WAIT_STATES(1)) u0 (
    .i_clk(clk), .i_reset_n(rst_n), .i_req_valid(req_valid[0]), .o_req_ready(req_ready[0]),
    .i_req_addr(addr), .i_req_we(we), .i_req_wdata(wdata), .i_req_be(be),
    .o_rsp_valid(rsp_valid[0]), .i_rsp_ready(rsp_ready[0]), .o_rsp_rdata(rdata[0]), .o_rsp_err(err[0]));
  dmem_responder #(.W(32), .D(8), .WAIT_STATES(0)) u1 (
    .i_clk(clk), .i_reset_n(rst_n), .i_req_valid(req_valid[1]), .o_req_ready(req_ready[1]),
    .i_req_addr(addr), .i_req_we(we), .i_req_wdata(wdata), .i_req_be(be),
    .o_rsp_valid(rsp_valid[1]), .i_rsp_ready(rsp_ready[1]), .o_rsp_rdata(rdata[1]), .o_rsp_err(err[1]));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rsp_valid[0] && rsp_ready[0]) begin
      if (q0.size() == 0) chk("u0 unexpected response", 32'(q0.size()), 32'd1);
      else begin
        e0 = q0.pop_front();
        chk("u0 rsp rdata", rdata[0], e0.rdata);
        chk("u0 rsp err", 32'(err[0]), 32'(e0.err));
      end
    end
    if (rsp_valid[1] && rsp_ready[1]) begin
      if (q1.size() == 0) chk("u1 unexpected response", 32'(q1.size()), 32'd1);
      else begin
        e1 = q1.pop_front();
        chk("u1 rsp rdata", rdata[1], e1.rdata);
        chk("u1 rsp err", 32'(err[1]), 32'(e1.err));
      end
    end
  end
  task automatic req(input int s, input logic [7:0] a, input logic w, input logic [31:0] d,
                     input logic [3:0] b, input logic [31:0] xr, input logic xe, input int xlat,
                     input string name);
    int n;
    if (s == 0) q0.push_back(exp_t'({xr, xe})); else q1.push_back(exp_t'({xr, xe}));
    addr = a; we = w; wdata = d; be = b; req_valid[s] = 1'b1;
    n = 0;
    while (!req_ready[s] && n < 20) begin @(posedge clk); #1; n++; end
    chk({name, " req_ready"}, 32'(req_ready[s]), 32'd1);
    @(posedge clk); #1;
    req_valid[s] = 1'b0;
    n = 0;
    while (!rsp_valid[s] && n < 40) begin @(posedge clk); #1; n++; end
    chk({name, " latency"}, 32'(n), 32'(xlat));
    if (rsp_ready[s]) begin @(posedge clk); #1; end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    req_valid[0] = 0; req_valid[1] = 0; rsp_ready[0] = 1; rsp_ready[1] = 1;
    addr = 0; we = 0; wdata = 0; be = 0;
    #12;
    for (int s = 0; s < 2; s++) begin
      chk("reset rsp_valid", 32'(rsp_valid[s]), 32'd0);
      chk("reset rdata", rdata[s], 32'd0);
      chk("reset err", 32'(err[s]), 32'd0);
      chk("reset req_ready", 32'(req_ready[s]), 32'd1);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post-reset req_ready", 32'(req_ready[0]), 32'd1);
    req(0, 8'h10, 1, 32'hDEADBEEF, 4'hF, 32'h0, 0, 2, "wr full");
    req(0, 8'h10, 0, 32'h0, 4'h0, 32'hDEADBEEF, 0, 2, "rd full");
    req(0, 8'h10, 1, 32'h11223344, 4'b0101, 32'h0, 0, 2, "wr be");
    req(0, 8'h10, 0, 32'h0, 4'h0, 32'hDE22BE44, 0, 2, "rd be");
    req(0, 8'h13, 1, 32'hFFFFFFFF, 4'hF, 32'h0, 1, 2, "wr misaligned");
    req(0, 8'h11, 0, 32'h0, 4'h0, 32'h0, 1, 2, "rd misaligned");
    req(0, 8'h10, 1, 32'h0, 4'h0, 32'h0, 0, 2, "wr be0");
    req(0, 8'h10, 0, 32'h0, 4'h0, 32'hDE22BE44, 0, 2, "rd after mis");
    rsp_ready[0] = 1'b0;
    req(0, 8'h10, 0, 32'h0, 4'h0, 32'hDE22BE44, 0, 2, "rd backpressure");
    addr = 8'h14; req_valid[0] = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp rsp_valid", 32'(rsp_valid[0]), 32'd1);
      chk("bp rdata", rdata[0], 32'hDE22BE44);
      chk("bp req_ready", 32'(req_ready[0]), 32'd0);
    end
    req_valid[0] = 1'b0; rsp_ready[0] = 1'b1;
    @(posedge clk); #1;
    chk("bp release req_ready", 32'(req_ready[0]), 32'd1);
    chk("bp release rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("bp release rdata", rdata[0], 32'd0);
    rsp_ready[0] = 1'b0;
    req(0, 8'h10, 0, 32'h0, 4'h0, 32'hDE22BE44, 0, 2, "rd pre-reset");
    #2 rst_n = 1'b0;
    q0.delete();
    #1;
    chk("async reset rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("async reset rdata", rdata[0], 32'd0);
    chk("async reset req_ready", 32'(req_ready[0]), 32'd1);
    rsp_ready[0] = 1'b1;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    req(0, 8'h20, 1, 32'hA5A5A5A5, 4'hF, 32'h0, 0, 2, "wr 20");
    addr = 8'h20; we = 1'b1; wdata = 32'h12345678; be = 4'hF; req_valid[0] = 1'b1;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    chk("in wait req_ready", 32'(req_ready[0]), 32'd0);
    rst_n = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("aborted no rsp", 32'(rsp_valid[0]), 32'd0);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    req(0, 8'h20, 0, 32'h0, 4'h0, 32'hA5A5A5A5, 0, 2, "rd 20 after abort");
    req(1, 8'h04, 1, 32'hCAFEF00D, 4'hF, 32'h0, 0, 1, "u1 wr");
    req(1, 8'h04, 0, 32'h0, 4'h0, 32'hCAFEF00D, 0, 1, "u1 rd");
    req(1, 8'h06, 0, 32'h0, 4'h0, 32'h0, 1, 1, "u1 rd misaligned");
    req(1, 8'h04, 1, 32'h0000AB00, 4'b0010, 32'h0, 0, 1, "u1 wr be");
    req(1, 8'h04, 0, 32'h0, 4'h0, 32'hCAFEAB0D, 0, 1, "u1 rd be");
    repeat (2) @(posedge clk);
    chk("u0 scoreboard drained", 32'(q0.size()), 32'd0);
    chk("u1 scoreboard drained", 32'(q1.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
